// File: rtl/decodificador_pkg.sv
// Shared types and Gray-code step classification for the quadrature decoder.
package decodificador_pkg;

    localparam int NBITS_COUNT = 2;

    typedef logic [1:0] fase_t;

    typedef enum logic {INIT, RUN} estado_t;

    localparam fase_t FASE_00 = 2'b00;
    localparam fase_t FASE_01 = 2'b01;
    localparam fase_t FASE_11 = 2'b11;
    localparam fase_t FASE_10 = 2'b10;

    typedef struct packed {
        logic valid;
        logic up;
        logic illegal;
    } passo_t;

    // Next phase in the forward (count-up) direction.
    function automatic fase_t proxima(input fase_t f);
        fase_t n;
        case (f)
            FASE_00: n = FASE_01;
            FASE_01: n = FASE_11;
            FASE_11: n = FASE_10;
            default: n = FASE_00;
        endcase
        return n;
    endfunction

    function automatic passo_t passo(input fase_t prev, input fase_t cur);
        passo_t p;
        p = '0;
        if (cur == proxima(prev)) begin
            p.valid = 1'b1;
            p.up    = 1'b1;
        end else if (prev == proxima(cur)) begin
            p.valid = 1'b1;
        end else if ((prev ^ cur) == 2'b11) begin
            p.illegal = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Single-bit multi-flop synchroniser for an asynchronous input.
module sincronizador #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] etapas;

    always_ff @(posedge clk) begin
        if (reset) begin
            etapas <= '0;
        end else begin
            etapas <= {etapas[SYNC_STAGES-2:0], d};
        end
    end

    assign q = etapas[SYNC_STAGES-1];

endmodule

// File: rtl/decodificador_quadratura.sv
// Quadrature decoder: synchronised A/B phases, step pulse with direction,
// loadable wrap-around position count and sticky illegal-transition flag.
module decodificador_quadratura
    import decodificador_pkg::*;
#(
    parameter int NBITS_COUNT = decodificador_pkg::NBITS_COUNT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_in,
    input  logic                   b_in,
    input  logic                   load,
    input  logic [NBITS_COUNT-1:0] Data_in,
    input  logic                   clear_err,
    output logic                   counter_on,
    output logic                   count_up,
    output logic [NBITS_COUNT-1:0] Count,
    output logic                   err
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(SYNC_STAGES);

    logic a_sync, b_sync;
    fase_t ph;
    passo_t p;

    estado_t state_q, state_d;
    logic [CW-1:0] init_cnt_q, init_cnt_d;
    fase_t prev_q, prev_d;
    logic [NBITS_COUNT-1:0] count_q, count_d;
    logic counter_on_q, counter_on_d;
    logic count_up_q, count_up_d;
    logic err_q, err_d;

    sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk  (clk),
        .reset(reset),
        .d    (a_in),
        .q    (a_sync)
    );

    sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk  (clk),
        .reset(reset),
        .d    (b_in),
        .q    (b_sync)
    );

    assign ph = {a_sync, b_sync};
    assign p  = passo(prev_q, ph);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            prev_q       <= FASE_00;
            count_q      <= '0;
            counter_on_q <= 1'b0;
            count_up_q   <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            prev_q       <= prev_d;
            count_q      <= count_d;
            counter_on_q <= counter_on_d;
            count_up_q   <= count_up_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        prev_d       = prev_q;
        count_d      = count_q;
        counter_on_d = 1'b0;
        count_up_d   = count_up_q;
        err_d        = err_q;

        unique case (state_q)
            INIT: begin
                // ph mirrors the pins only once the reset zeros have left the chain
                if (init_cnt_q == INIT_LAST) begin
                    prev_d  = ph;
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                prev_d = ph;
                if (p.valid) begin
                    counter_on_d = 1'b1;
                    count_up_d   = p.up;
                    count_d      = p.up ? count_q + 1'b1 : count_q - 1'b1;
                end
            end
            default: state_d = INIT;
        endcase

        if (state_q == RUN && p.illegal) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end

        if (load) begin
            count_d = Data_in;
        end
    end

    assign counter_on = counter_on_q;
    assign count_up   = count_up_q;
    assign Count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_decodificador_quadratura.sv
// Scoreboard bench for decodificador_quadratura: expected step pulses are
// queued when phases are driven and popped when counter_on fires.
module tb_decodificador_quadratura;

    localparam int NB = 2;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_in = 1'b0;
    logic          b_in = 1'b0;
    logic          load = 1'b0;
    logic [NB-1:0] Data_in = '0;
    logic          clear_err = 1'b0;
    logic          counter_on;
    logic          count_up;
    logic [NB-1:0] Count;
    logic          err;

    decodificador_quadratura #(.NBITS_COUNT(NB), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_in      (a_in),
        .b_in      (b_in),
        .load      (load),
        .Data_in   (Data_in),
        .clear_err (clear_err),
        .counter_on(counter_on),
        .count_up  (count_up),
        .Count     (Count),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        bit          up;
        logic [NB-1:0] cnt;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0;
    int n_pass = 0;

    logic [1:0]    m_ph = 2'b00;
    logic [NB-1:0] m_cnt = '0;
    bit            m_err = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Position of a phase along the forward sequence 00,01,11,10.
    function automatic int pos(input logic [1:0] f);
        case (f)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (counter_on) begin
            if (sbq.size() == 0) begin
                check_eq("spurious_pulse", 1, 0);
            end else begin
                e = sbq.pop_front();
                check_eq("pulse_cycle", cyc, e.cyc);
                check_eq("pulse_dir", int'(count_up), int'(e.up));
                check_eq("pulse_count", int'(Count), int'(e.cnt));
            end
        end
    end

    // Drive a new phase; load/clear_err are applied on the edge that registers the step.
    task automatic drive(input logic [1:0] ph, input bit ld, input logic [NB-1:0] ldv,
                         input bit clr, output int d);
        exp_t e;
        {a_in, b_in} = ph;
        d = (pos(ph) - pos(m_ph)) & 3;
        if (d == 1) m_cnt = m_cnt + 1'b1;
        if (d == 3) m_cnt = m_cnt - 1'b1;
        if (ld) m_cnt = ldv;
        if (d == 2) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (d == 1 || d == 3) begin
            e.cyc = cyc + SS + 1;
            e.up  = (d == 1);
            e.cnt = m_cnt;
            sbq.push_back(e);
        end
        m_ph = ph;
    endtask

    task automatic step(input logic [1:0] ph, input bit ld = 1'b0,
                        input logic [NB-1:0] ldv = '0, input bit clr = 1'b0);
        int d;
        @(negedge clk);
        drive(ph, ld, ldv, clr, d);
        repeat (2) @(negedge clk);
        load = ld;
        Data_in = ldv;
        clear_err = clr;
        @(negedge clk);
        load = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("count_hold", int'(Count), int'(m_cnt));
        check_eq("err", int'(err), int'(m_err));
        check_eq("sb_empty", sbq.size(), 0);
    endtask

    task automatic do_reset(input logic [1:0] ph);
        @(negedge clk);
        reset = 1'b1;
        {a_in, b_in} = ph;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        m_ph = ph;
        m_cnt = '0;
        m_err = 1'b0;
        sbq.delete();
        check_eq("rst_count", int'(Count), 0);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_on", int'(counter_on), 0);
        check_eq("rst_up", int'(count_up), 1);
    endtask

    initial begin
        int d;
        do_reset(2'b11);
        // prev must be 11: 10 and 00 are then forward steps, not errors
        step(2'b10);
        step(2'b00);

        @(negedge clk);
        load = 1'b1;
        Data_in = '0;
        @(negedge clk);
        load = 1'b0;
        m_cnt = '0;
        check_eq("load_only", int'(Count), 0);

        step(2'b01);
        step(2'b11);
        step(2'b10);
        step(2'b00);   // 3 -> 0 wrap
        step(2'b10);   // 0 -> 3 underflow
        step(2'b11);
        step(2'b01);
        step(2'b00);

        step(2'b11);   // illegal
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        m_err = 1'b0;
        check_eq("clear_err", int'(err), 0);
        step(2'b00, 1'b0, '0, 1'b1);   // illegal with coincident clear

        step(2'b01);
        step(2'b11, 1'b1, 2'd2);       // load beats step
        check_eq("load_dir", int'(count_up), 1);
        step(2'b10);

        // reset while counter_on is high
        @(negedge clk);
        drive(2'b00, 1'b0, '0, 1'b0, d);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_on", int'(counter_on), 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_on", int'(counter_on), 0);
        check_eq("mid_rst_count", int'(Count), 0);
        check_eq("mid_rst_err", int'(err), 0);
        check_eq("mid_rst_sb", sbq.size(), 0);
        do_reset(2'b00);
        step(2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
